multiplier_interface: RTL and testbench

- Consumer end of the divider-to-multiplier link. Accepts divider results {quotient, remainder} through a write-request port into an internal FIFO, and signals back-pressure with full_out.
- A sequential shift-add engine computes quotient*remainder for each entry.
- Each product is handed downstream with a one-cycle done_sig strobe, gated by the downstream full_in.

---
 rtl/multiplier_interface_pkg.sv | 22 ++
 rtl/multiplier_interface_if.sv | 37 +++
 rtl/multiplier_interface_sync_fifo.sv | 77 +++++++
 rtl/multiplier_interface.sv | 122 ++++++++++++
 tb/tb_multiplier_interface.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/multiplier_interface_pkg.sv
`default_nettype none
// ============================================================================
// Module  : multiplier_interface_pkg
// Brief   : Shared widths and FSM encoding for the divider-to-multiplier link.
// Revision: 1.0
// ============================================================================
package multiplier_interface_pkg;

    localparam int DATA_W = 16;
    localparam int OPER_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_MUL  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/multiplier_interface_if.sv
`default_nettype none
// ============================================================================
// Module  : multiplier_interface_if
// Brief   : Upstream write port plus downstream result hand-off bundle.
// Revision: 1.0
// ============================================================================
interface multiplier_interface_if
    import multiplier_interface_pkg::*;
();

    logic                  write_req;
    logic [DATA_W-1:0]     fifo_write_data;
    logic                  full_out;
    logic [2*OPER_W-1:0]   product;
    logic                  full_in;
    logic                  done_sig;

    modport master (
        output write_req,
        output fifo_write_data,
        input  full_out,
        input  product,
        output full_in,
        input  done_sig
    );

    modport slave (
        input  write_req,
        input  fifo_write_data,
        output full_out,
        output product,
        input  full_in,
        output done_sig
    );

endinterface
`default_nettype wire

// File: rtl/multiplier_interface_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sync_fifo
// Brief   : Count-based synchronous FIFO with registered read data.
// Revision: 1.0
// ============================================================================
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0] c_one   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   w_count_nxt;
    logic              r_full;
    logic              w_do_wr;
    logic              w_do_rd;

    // A pop in the same cycle frees a slot, so a write at full is still taken.
    assign w_do_rd = rd_en && (r_count != '0);
    assign w_do_wr = wr_en && (!r_full || w_do_rd);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_wr, w_do_rd})
            2'b10:   w_count_nxt = r_count + c_one;
            2'b01:   w_count_nxt = r_count - c_one;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            dout     <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                dout     <= r_mem[r_rd_ptr];
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_depth);
        end
    end

    assign full  = r_full;
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/multiplier_interface.sv
`default_nettype none
// ============================================================================
// Module  : multiplier_interface
// Brief   : Buffers {quotient, remainder} words and emits their shift-add product.
// Revision: 1.0
// ============================================================================
module multiplier_interface
    import multiplier_interface_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    multiplier_interface_if.slave bus
);

    localparam int             CNT_W      = $clog2(OPER_W);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(OPER_W - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_rd_en;
    logic [DATA_W-1:0]     w_fifo_dout;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;

    logic [2*OPER_W-1:0]   r_op_a;
    logic [OPER_W-1:0]     r_op_b;
    logic [2*OPER_W-1:0]   r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic [2*OPER_W-1:0]   r_product;
    logic                  r_done;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (bus.write_req),
        .din   (bus.fifo_write_data),
        .rd_en (w_rd_en),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_rd_en     = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: w_state_nxt = ST_MUL;
            ST_MUL: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (!bus.full_in) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand A is held at full product width so each left shift keeps its bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    r_op_a <= {{OPER_W{1'b0}}, w_fifo_dout[DATA_W-1 -: OPER_W]};
                    r_op_b <= w_fifo_dout[OPER_W-1:0];
                    r_acc  <= '0;
                    r_cnt  <= '0;
                end
                ST_MUL: begin
                    if (r_op_b[0]) begin
                        r_acc <= r_acc + r_op_a;
                    end
                    r_op_a <= r_op_a << 1;
                    r_op_b <= r_op_b >> 1;
                    r_cnt  <= r_cnt + 1'b1;
                end
                ST_OUT: begin
                    if (!bus.full_in) begin
                        r_product <= r_acc;
                        r_done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.full_out = w_fifo_full;
    assign bus.product  = r_product;
    assign bus.done_sig = r_done;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_interface.sv
`default_nettype none
// ============================================================================
// Module  : tb_multiplier_interface
// Brief   : Randomized and directed bench against a queue-based reference model.
// Revision: 1.0
// ============================================================================
module tb_multiplier_interface;
    import multiplier_interface_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multiplier_interface_if bus();

    multiplier_interface dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of waiting words and a countdown for the engine.
    logic [15:0] m_q[$];
    logic [15:0] m_cur;
    bit          m_idle = 1'b1;
    int          m_wait = 0;
    bit          m_pop;
    bit          m_acc;
    bit          exp_done = 1'b0;
    logic [15:0] exp_prod = 16'h0;
    bit          exp_full = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_idle   = 1'b1;
            m_wait   = 0;
            exp_done = 1'b0;
            exp_prod = 16'h0;
            exp_full = 1'b0;
        end else begin
            m_pop    = m_idle && (m_q.size() > 0);
            m_acc    = bus.write_req && ((m_q.size() < DEPTH) || m_pop);
            exp_done = 1'b0;
            if (m_idle) begin
                if (m_pop) begin
                    m_cur  = m_q.pop_front();
                    m_wait = 9;
                    m_idle = 1'b0;
                end
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (!bus.full_in) begin
                exp_done = 1'b1;
                exp_prod = 16'(int'(m_cur[15:8]) * int'(m_cur[7:0]));
                m_idle   = 1'b1;
            end
            if (m_acc) m_q.push_back(bus.fifo_write_data);
            exp_full = (m_q.size() == DEPTH);
        end
    end

    int          n_done = 0;
    logic [15:0] got[$];

    always @(negedge clk) begin
        if (rst_n) begin
            chk("done_sig", 32'(bus.done_sig), 32'(exp_done));
            chk("product", 32'(bus.product), 32'(exp_prod));
            chk("full_out", 32'(bus.full_out), 32'(exp_full));
            if (bus.done_sig) begin
                n_done++;
                got.push_back(bus.product);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = -1;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk);
            #1;
            if (n == 0) bus.write_req = 1'b0;
            if (bus.done_sig) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic single(input logic [15:0] data, input logic [15:0] exp);
        int lat;
        bus.fifo_write_data = data;
        bus.write_req       = 1'b1;
        wait_done(30, lat);
        chk("latency", 32'(lat), 32'd11);
        chk("single product", 32'(bus.product), 32'(exp));
        repeat (3) tick();
        chk("product held", 32'(bus.product), 32'(exp));
        chk("done low after strobe", 32'(bus.done_sig), 32'd0);
    endtask

    initial begin
        int seen;
        int base;
        int done_snap;

        bus.write_req       = 1'b0;
        bus.fifo_write_data = 16'h0;
        bus.full_in         = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset product", 32'(bus.product), 32'd0);
        chk("reset done", 32'(bus.done_sig), 32'd0);
        chk("reset full_out", 32'(bus.full_out), 32'd0);
        rst_n = 1'b1;
        tick();

        single(16'h0C05, 16'h003C);
        single(16'hFFFF, 16'hFE01);
        single(16'h00FF, 16'h0000);

        // Back-pressure: result parks until full_in drops.
        bus.full_in         = 1'b1;
        bus.fifo_write_data = 16'h0303;
        bus.write_req       = 1'b1;
        tick();
        bus.write_req = 1'b0;
        seen = 0;
        for (int c = 1; c < 30; c++) begin
            tick();
            if (bus.done_sig) seen = 1;
        end
        chk("no done under full_in", 32'(seen), 32'd0);
        chk("product unchanged under full_in", 32'(bus.product), 32'h0);
        bus.full_in = 1'b0;
        @(posedge clk);
        #1;
        chk("done after release", 32'(bus.done_sig), 32'd1);
        chk("product after release", 32'(bus.product), 32'h0009);
        #1;

        // Fill the FIFO behind a parked result, then overflow it.
        bus.full_in = 1'b1;
        tick();
        for (int i = 1; i <= 17; i++) begin
            bus.fifo_write_data = 16'(16'h0100 + i);
            bus.write_req       = 1'b1;
            tick();
        end
        chk("full after 17 writes", 32'(bus.full_out), 32'd1);
        bus.fifo_write_data = 16'h2222;
        tick();
        bus.write_req = 1'b0;
        chk("full after dropped write", 32'(bus.full_out), 32'd1);
        tick();
        base = got.size();
        done_snap = n_done;
        bus.full_in = 1'b0;
        tick();
        bus.fifo_write_data = 16'h0203;
        bus.write_req       = 1'b1;
        tick();
        bus.write_req = 1'b0;
        chk("full across pop+write", 32'(bus.full_out), 32'd1);
        repeat (18 * 11 + 20) tick();
        chk("drain done count", 32'(n_done - done_snap), 32'd18);
        if (got.size() >= base + 18) begin
            for (int i = 0; i < 17; i++) chk("drain order", 32'(got[base+i]), 32'(i + 1));
            chk("simultaneous write product", 32'(got[base+17]), 32'h0006);
        end else begin
            chk("drain result count", 32'(got.size() - base), 32'd18);
        end
        chk("empty after drain", 32'(bus.full_out), 32'd0);

        // Randomized traffic with intermittent back-pressure.
        for (int c = 0; c < 400; c++) begin
            bus.write_req       = ($urandom_range(0, 3) == 0);
            bus.fifo_write_data = 16'($urandom);
            bus.full_in         = ($urandom_range(0, 4) == 0);
            tick();
        end
        bus.write_req = 1'b0;
        bus.full_in   = 1'b0;
        repeat (17 * 11 + 30) tick();

        // Reset while the engine is busy with more entries queued.
        for (int i = 0; i < 4; i++) begin
            bus.fifo_write_data = 16'(16'h1111 * (i + 1));
            bus.write_req       = 1'b1;
            tick();
        end
        bus.write_req = 1'b0;
        repeat (3) tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("async reset done", 32'(bus.done_sig), 32'd0);
        chk("async reset product", 32'(bus.product), 32'd0);
        chk("async reset full_out", 32'(bus.full_out), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        done_snap = n_done;
        repeat (30) tick();
        chk("no done after reset", 32'(n_done - done_snap), 32'd0);
        single(16'h0A0B, 16'h006E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
